// File: rtl/voice_allocator.sv
// Voice allocator: routes one stream of note requests onto NUM_VOICES note
// players. A free voice is preferred (lowest index). When every voice is busy,
// the least-recently-loaded voice is either stolen or the requester is stalled.

// One voice: load strobe, busy flag, age rank and the held note/duration.
module voice_slot #(
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int RW       = 2,
  parameter int RST_RANK = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,      // this voice is the one being loaded
  input  logic              any_load,  // some voice is being loaded this cycle
  input  logic [RW-1:0]     sel_rank,  // rank of the voice being loaded
  input  logic              done,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  dur,
  output logic              load_q,
  output logic              busy_q,
  output logic [RW-1:0]     rank_q,
  output logic [NOTE_W-1:0] note_q,
  output logic [DUR_W-1:0]  dur_q
);
  logic              load_d, busy_d;
  logic [RW-1:0]     rank_d;
  logic [NOTE_W-1:0] note_d;
  logic [DUR_W-1:0]  dur_d;

  // next state: flush clears busy/age but keeps note/duration so players hold
  always_comb begin
    load_d = 1'b0;
    busy_d = busy_q;
    rank_d = rank_q;
    note_d = note_q;
    dur_d  = dur_q;
    if (flush) begin
      busy_d = 1'b0;
      rank_d = RW'(RST_RANK);
    end else if (load) begin
      // a load beats a same-cycle done on this voice
      load_d = 1'b1;
      busy_d = 1'b1;
      rank_d = '0;
      note_d = note;
      dur_d  = dur;
    end else begin
      if (done) busy_d = 1'b0;
      if (any_load && (rank_q < sel_rank)) rank_d = rank_q + RW'(1);
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q <= 1'b0;
      busy_q <= 1'b0;
      rank_q <= RW'(RST_RANK);
      note_q <= '0;
      dur_q  <= '0;
    end else begin
      load_q <= load_d;
      busy_q <= busy_d;
      rank_q <= rank_d;
      note_q <= note_d;
      dur_q  <= dur_d;
    end
  end
endmodule

module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int STEAL_EN   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         req_valid,
  input  logic [NOTE_W-1:0]            req_note,
  input  logic [DUR_W-1:0]             req_duration,
  output logic                         req_ready,
  input  logic [NUM_VOICES-1:0]        voice_done,
  output logic [NUM_VOICES-1:0]        load_new_note,
  output logic [NUM_VOICES*NOTE_W-1:0] note_to_load,
  output logic [NUM_VOICES*DUR_W-1:0]  duration_to_load,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic                         stolen
);
  localparam int RW = $clog2(NUM_VOICES);

  logic                                steal_en;
  logic                                all_busy;
  logic                                accept;
  logic [NUM_VOICES-1:0]               sel_oh;
  logic [NUM_VOICES-1:0]               load_oh;
  logic [RW-1:0]                       sel_rank;
  logic                                found;
  logic [NUM_VOICES-1:0][RW-1:0]       rank;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]   note_q;
  logic [NUM_VOICES-1:0][DUR_W-1:0]    dur_q;
  logic                                stolen_d, stolen_q;

  assign steal_en  = (STEAL_EN != 0);
  assign all_busy  = &voice_busy;
  assign req_ready = ~flush & ~reset & (~all_busy | steal_en);
  assign accept    = req_valid & req_ready;
  assign load_oh   = accept ? sel_oh : '0;

  // voice pick: lowest free index, else the oldest (rank NUM_VOICES-1)
  always_comb begin
    sel_oh   = '0;
    found    = 1'b0;
    sel_rank = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!voice_busy[v] && !found) begin
        sel_oh[v] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (rank[v] == RW'(NUM_VOICES-1)) sel_oh[v] = 1'b1;
    end
    for (int v = 0; v < NUM_VOICES; v++)
      if (sel_oh[v]) sel_rank = rank[v];
  end

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      voice_slot #(
        .NOTE_W  (NOTE_W),
        .DUR_W   (DUR_W),
        .RW      (RW),
        .RST_RANK(NUM_VOICES-1-v)
      ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (load_oh[v]),
        .any_load(accept),
        .sel_rank(sel_rank),
        .done    (voice_done[v]),
        .note    (req_note),
        .dur     (req_duration),
        .load_q  (load_new_note[v]),
        .busy_q  (voice_busy[v]),
        .rank_q  (rank[v]),
        .note_q  (note_q[v]),
        .dur_q   (dur_q[v])
      );
    end
  endgenerate

  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;

  // steal flag, aligned with the load strobe it belongs to
  always_comb begin
    stolen_d = accept & all_busy;
  end

  // steal flag register
  always_ff @(posedge clk) begin
    if (reset) stolen_q <= 1'b0;
    else       stolen_q <= stolen_d;
  end

  assign stolen = stolen_q;
endmodule
